spi_host_master: RTL and testbench
==================================

// Module: spi_host_master
// PURPOSE
//  SPI host-side initiator for the MiST-style control link (user_io / data_io / OSD).
//  Drives SPI_SCK, SPI_DI and the three active-low selects; samples SPI_DO.
//  Frames one command byte followed by N payload bytes.
//  Used as an on-FPGA controller replacement and as the link BFM for core-side slave regression.
// PARAMETERS
//  CLK_DIV   4   clk_sys cycles per SCK half-period (>=2)
//  LEN_W     16  width of payload length field
//  CS_SETUP  2   clk_sys cycles select-low before first SCK rise, also select-high hold after last fall
// PORTS
//  clk_sys       in   1      system clock, single clock domain
//  reset_n       in   1      synchronous, active-low reset
//  req_valid     in   1      transaction request
//  req_ready     out  1      high in IDLE only; accept = req_valid & req_ready
//  req_target    in   2      0=user_io(CONF_DATA0) 1=data_io(SPI_SS2) 2=OSD(SPI_SS3) 3=reserved
//  req_cmd       in   8      command byte, sent first
//  req_len       in   LEN_W  payload bytes after command; 0 allowed
//  tx_data       in   8      next payload byte
//  tx_valid      in   1      tx_data valid
//  tx_ready      out  1      1-cycle pop strobe when byte is loaded into shifter
//  rx_data       out  8      byte shifted in from SPI_DO
//  rx_valid      out  1      1-cycle pulse per payload byte; no backpressure
//  done          out  1      1-cycle pulse when select deasserts
//  err           out  1      1-cycle pulse on reserved target
//  busy          out  1      ~IDLE
//  spi_sck       out  1      to SPI_SCK; idles low (mode 0)
//  spi_mosi      out  1      to SPI_DI; MSB first
//  spi_miso      in   1      from SPI_DO
//  spi_ss2_n     out  1      data_io select
//  spi_ss3_n     out  1      OSD select
//  conf_data0_n  out  1      user_io select
// BEHAVIOUR
//  Reset: all selects 1, spi_sck 0, spi_mosi 0, rx_data 0, strobes 0, busy 0, FSM IDLE.
//    Applies mid-transfer; pins return to idle the cycle after reset_n is sampled low.
//  FSM: IDLE -> SETUP -> SHIFT -> (LOAD -> SHIFT)* -> HOLD -> IDLE.
//  IDLE: on accept latch target, cmd, len.
//    target 3 -> err pulse, no select, no SCK, stay IDLE, no done.
//  SETUP: select for latched target low for CS_SETUP cycles; mosi = cmd[7].
//  SHIFT: 8 bits, each 2*CLK_DIV cycles; mosi updated while SCK low.
//    SCK rises after CLK_DIV cycles; miso sampled on the rising-edge cycle; SCK falls CLK_DIV later.
//  After each byte: if remaining payload == 0 -> HOLD; else LOAD.
//  LOAD: wait for tx_valid; SCK low and select held low while starved (no edges).
//    On tx_valid pulse tx_ready, load shifter, go SHIFT.
//  rx_valid + rx_data asserted the cycle after the 8th falling edge of each payload byte.
//    The command byte's rx is discarded.
//  HOLD: SCK low CS_SETUP cycles; select high; done pulse same cycle select rises; then IDLE.
//  Payload counter LEN_W bits; len = 2^LEN_W-1 must not wrap.
//  req_len=0: command byte only, then HOLD.
//  Only one select low at any time; select never changes while SCK high.
// STRUCTURE
//  Package spi_host_pkg: target enum (TGT_USER_IO, TGT_DATA_IO, TGT_OSD, TGT_RSVD), FSM state enum.
//  Sub-module spi_host_shifter: 8-bit shift register, SCK divider, bit counter;
//    byte_start / byte_done handshake to the FSM.
// TESTING
//  1. target 0, cmd 0x14, len 0: conf_data0_n low 16*CLK_DIV+2*CS_SETUP cycles,
//     8 SCK rises, mosi 0,0,0,1,0,1,0,0, one done, no rx_valid.
//  2. target 1, cmd 0x55, len 2, tx 0xA5,0x3C, slave returns 0x81,0x7E:
//     spi_ss2_n only; rx_valid twice with 0x81 then 0x7E; two tx_ready.
//  3. tx starvation: len 1, tx_valid held low 50 cycles:
//     SCK low and spi_ss3_n low throughout; transfer completes after tx_valid rises.
//  4. target 3: err pulse, all selects stay high, no SCK, req_ready stays high.
//  5. reset_n low mid-bit of payload byte: next cycle all selects 1, sck 0, busy 0;
//     a fresh request then completes correctly.
//  6. back-to-back: req_valid held with 2 requests:
//     select high >= CS_SETUP cycles between frames, done per frame.

Source files
------------

// File: rtl/spi_host_pkg.sv
// Shared types for the SPI host master: select targets and frame FSM states.
package spi_host_pkg;

    typedef enum logic [1:0] {
        TGT_USER_IO = 2'd0,
        TGT_DATA_IO = 2'd1,
        TGT_OSD     = 2'd2,
        TGT_RSVD    = 2'd3
    } spi_target_e;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StLoad,
        StHold
    } spi_state_e;

endpackage

// File: rtl/spi_host_shifter.sv
// Mode-0 byte shifter: SCK divider, bit counter, MSB-first shift register.
module spi_host_shifter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       byte_start_i,
    input  logic [7:0] load_data_i,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o
);

    logic [7:0]  sh_q, sh_d;
    logic        miso_q, miso_d;
    logic        sck_q, sck_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic        half_end;

    assign half_end    = en_i && (div_q == 16'(CLK_DIV - 1));
    assign byte_done_o = half_end && sck_q && (bit_q == 3'd7);
    assign rx_byte_o   = {sh_q[6:0], miso_q};
    assign sck_o       = sck_q;
    assign mosi_o      = sh_q[7];

    always_comb begin
        sh_d   = sh_q;
        miso_d = miso_q;
        sck_d  = sck_q;
        div_d  = div_q;
        bit_d  = bit_q;
        if (byte_start_i) begin
            sh_d  = load_data_i;
            sck_d = 1'b0;
            div_d = '0;
            bit_d = '0;
        end else if (en_i) begin
            if (half_end) begin
                div_d = '0;
                sck_d = ~sck_q;
                if (!sck_q) begin
                    miso_d = miso_i;
                end else begin
                    // Shift only on the falling edge so MOSI moves while SCK is low.
                    sh_d  = {sh_q[6:0], miso_q};
                    bit_d = bit_q + 3'd1;
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_q   <= '0;
            miso_q <= 1'b0;
            sck_q  <= 1'b0;
            div_q  <= '0;
            bit_q  <= '0;
        end else begin
            sh_q   <= sh_d;
            miso_q <= miso_d;
            sck_q  <= sck_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// SPI host initiator for the MiST control link: one command byte then N payload bytes.
import spi_host_pkg::*;

module spi_host_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned CS_SETUP = 2
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_target,
    input  logic [7:0]       req_cmd,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_ss2_n,
    output logic             spi_ss3_n,
    output logic             conf_data0_n
);

    spi_state_e       state_q, state_d;
    spi_target_e      tgt_q, tgt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      guard_q, guard_d;
    logic             payload_q, payload_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rx_valid_q;
    logic [7:0]       rx_data_q;
    logic             accept, byte_start, byte_done, sel_active;
    logic [7:0]       load_data, rx_byte;

    // Guard keeps selects high for CS_SETUP cycles before a back-to-back frame.
    assign req_ready = (state_q == StIdle) && (guard_q == 16'd0);
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != StIdle);
    assign sel_active = (state_q != StIdle);

    assign conf_data0_n = !(sel_active && (tgt_q == TGT_USER_IO));
    assign spi_ss2_n    = !(sel_active && (tgt_q == TGT_DATA_IO));
    assign spi_ss3_n    = !(sel_active && (tgt_q == TGT_OSD));

    assign done     = done_q;
    assign err      = err_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        guard_d    = guard_q;
        payload_d  = payload_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        byte_start = 1'b0;
        load_data  = tx_data;
        tx_ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (guard_q != 16'd0) guard_d = guard_q - 16'd1;
                if (accept) begin
                    if (spi_target_e'(req_target) == TGT_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_d      = spi_target_e'(req_target);
                        rem_d      = req_len;
                        cnt_d      = '0;
                        payload_d  = 1'b0;
                        byte_start = 1'b1;
                        load_data  = req_cmd;
                        state_d    = StSetup;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == 16'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StShift: begin
                if (byte_done) begin
                    cnt_d   = '0;
                    state_d = (rem_q == '0) ? StHold : StLoad;
                end
            end
            StLoad: begin
                if (tx_valid) begin
                    tx_ready   = 1'b1;
                    byte_start = 1'b1;
                    load_data  = tx_data;
                    rem_d      = rem_q - LEN_W'(1);
                    payload_d  = 1'b1;
                    state_d    = StShift;
                end
            end
            StHold: begin
                if (cnt_q == 16'(CS_SETUP - 1)) begin
                    done_d  = 1'b1;
                    guard_d = 16'(CS_SETUP - 1);
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            tgt_q      <= TGT_USER_IO;
            rem_q      <= '0;
            cnt_q      <= '0;
            guard_q    <= '0;
            payload_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            guard_q    <= guard_d;
            payload_q  <= payload_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rx_valid_q <= byte_done && payload_q;
            if (byte_done && payload_q) rx_data_q <= rx_byte;
        end
    end

    spi_host_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk_i       (clk_sys),
        .rst_ni      (reset_n),
        .en_i        (state_q == StShift),
        .byte_start_i(byte_start),
        .load_data_i (load_data),
        .miso_i      (spi_miso),
        .sck_o       (spi_sck),
        .mosi_o      (spi_mosi),
        .byte_done_o (byte_done),
        .rx_byte_o   (rx_byte)
    );

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master with a bit-stream SPI slave model.
module tb_spi_host_master;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_target = 2'd0;
    logic [7:0]  req_cmd = 8'd0;
    logic [15:0] req_len = 16'd0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, done, err, busy;
    logic        spi_sck, spi_mosi, spi_miso;
    logic        spi_ss2_n, spi_ss3_n, conf_data0_n;

    spi_host_master #(
        .CLK_DIV (4),
        .LEN_W   (16),
        .CS_SETUP(2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_target  (req_target),
        .req_cmd     (req_cmd),
        .req_len     (req_len),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_ss2_n   (spi_ss2_n),
        .spi_ss3_n   (spi_ss3_n),
        .conf_data0_n(conf_data0_n)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    int sck_rises = 0, done_cnt = 0, err_cnt = 0, rx_cnt = 0;
    int lo_ss2 = 0, lo_ss3 = 0, lo_conf = 0, multi_sel = 0, sel_sck_viol = 0;
    int hi_run = 0, last_gap = 0;
    logic [31:0] mosi_sh = '0;
    logic [7:0]  rx_mem [16];
    logic [7:0]  tx_mem [16];
    int          tx_head = 0, tx_tail = 0;
    logic        tx_en = 1'b0;
    logic [2:0]  prev_sel = 3'b111;
    logic        prev_sck = 1'b0;
    logic        sel_all_n;
    logic [5:0]  slv_idx = '0;
    logic [63:0] slv_vec = '0;

    assign sel_all_n = spi_ss2_n & spi_ss3_n & conf_data0_n;
    // Slave shifts its next bit out on every SCK fall; frame end rewinds the stream.
    assign spi_miso = slv_vec[~slv_idx];

    always @(negedge spi_sck or posedge sel_all_n) begin
        if (sel_all_n) slv_idx = '0;
        else           slv_idx = slv_idx + 6'd1;
    end

    always @(posedge spi_sck) begin
        sck_rises++;
        mosi_sh = {mosi_sh[30:0], spi_mosi};
    end

    always @(posedge clk_sys) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (rx_valid) begin
            rx_mem[rx_cnt % 16] = rx_data;
            rx_cnt++;
        end
        if (tx_valid && tx_ready) tx_head++;
        if (!spi_ss2_n) lo_ss2++;
        if (!spi_ss3_n) lo_ss3++;
        if (!conf_data0_n) lo_conf++;
        if ($countones({~spi_ss2_n, ~spi_ss3_n, ~conf_data0_n}) > 1) multi_sel++;
        if (reset_n && ({spi_ss2_n, spi_ss3_n, conf_data0_n} != prev_sel) &&
            (spi_sck || prev_sck)) sel_sck_viol++;
        prev_sel = {spi_ss2_n, spi_ss3_n, conf_data0_n};
        prev_sck = spi_sck;
        if (sel_all_n) begin
            hi_run++;
        end else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    always @(negedge clk_sys) begin
        tx_valid = tx_en && (tx_head != tx_tail);
        tx_data  = tx_mem[tx_head % 16];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_tail % 16] = b;
        tx_tail++;
    endtask

    task automatic do_req(input logic [1:0] tgt, input logic [7:0] cmd,
                          input logic [15:0] len, input bit keep);
        int k;
        k = 0;
        req_target = tgt;
        req_cmd    = cmd;
        req_len    = len;
        req_valid  = 1'b1;
        do begin
            @(posedge clk_sys);
            k++;
        end while (!req_ready && k < 2000);
        check("req_accepted", 32'(req_ready), 32'd1);
        @(negedge clk_sys);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done(input int want);
        int k;
        k = 0;
        while (done_cnt < want && k < 3000) begin
            @(negedge clk_sys);
            k++;
        end
        check("done_reached", 32'(done_cnt), 32'(want));
    endtask

    int b_rise, b_done, b_rx, b_ss2, b_ss3, b_conf, b_err, b_tx, bad;

    task automatic snap();
        b_rise = sck_rises;
        b_done = done_cnt;
        b_rx   = rx_cnt;
        b_ss2  = lo_ss2;
        b_ss3  = lo_ss3;
        b_conf = lo_conf;
        b_err  = err_cnt;
        b_tx   = tx_head;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        cycles(3);
        check("rst_selects", 32'({spi_ss2_n, spi_ss3_n, conf_data0_n}), 32'h7);
        check("rst_sck_mosi", 32'({spi_sck, spi_mosi}), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_strobes", 32'({rx_valid, done, err, busy}), 32'h0);
        reset_n = 1'b1;
        cycles(2);
        check("idle_ready", 32'(req_ready), 32'd1);

        // 1: user_io, command only
        snap();
        do_req(2'd0, 8'h14, 16'd0, 1'b0);
        wait_done(b_done + 1);
        cycles(4);
        check("t1_conf_low_cycles", 32'(lo_conf - b_conf), 32'd68);
        check("t1_sck_rises", 32'(sck_rises - b_rise), 32'd8);
        check("t1_mosi", 32'(mosi_sh[7:0]), 32'h14);
        check("t1_done_count", 32'(done_cnt - b_done), 32'd1);
        check("t1_no_rx", 32'(rx_cnt - b_rx), 32'd0);
        check("t1_other_sel", 32'((lo_ss2 - b_ss2) + (lo_ss3 - b_ss3)), 32'd0);

        // 2: data_io, two payload bytes
        snap();
        slv_vec = {8'h00, 8'h81, 8'h7E, 40'h0};
        push_tx(8'hA5);
        push_tx(8'h3C);
        tx_en = 1'b1;
        do_req(2'd1, 8'h55, 16'd2, 1'b0);
        wait_done(b_done + 1);
        cycles(4);
        check("t2_rx_count", 32'(rx_cnt - b_rx), 32'd2);
        check("t2_rx0", 32'(rx_mem[b_rx % 16]), 32'h81);
        check("t2_rx1", 32'(rx_mem[(b_rx + 1) % 16]), 32'h7E);
        check("t2_tx_pops", 32'(tx_head - b_tx), 32'd2);
        check("t2_ss2_low_cycles", 32'(lo_ss2 - b_ss2), 32'd198);
        check("t2_other_sel", 32'((lo_conf - b_conf) + (lo_ss3 - b_ss3)), 32'd0);
        check("t2_mosi", mosi_sh[23:0], 32'h55A53C);
        check("t2_sck_rises", 32'(sck_rises - b_rise), 32'd24);

        // 3: OSD, tx starvation
        snap();
        tx_en = 1'b0;
        push_tx(8'h96);
        slv_vec = {8'h00, 8'hC3, 48'h0};
        do_req(2'd2, 8'hE7, 16'd1, 1'b0);
        cycles(70);
        check("t3_cmd_rises", 32'(sck_rises - b_rise), 32'd8);
        bad = 0;
        repeat (50) begin
            @(negedge clk_sys);
            if (spi_sck || spi_ss3_n) bad++;
        end
        check("t3_starved_idle_pins", 32'(bad), 32'd0);
        check("t3_starved_rises", 32'(sck_rises - b_rise), 32'd8);
        tx_en = 1'b1;
        wait_done(b_done + 1);
        cycles(4);
        check("t3_rx_count", 32'(rx_cnt - b_rx), 32'd1);
        check("t3_rx0", 32'(rx_mem[b_rx % 16]), 32'hC3);
        check("t3_mosi", mosi_sh[15:0], 32'hE796);
        check("t3_tx_pops", 32'(tx_head - b_tx), 32'd1);

        // 4: reserved target
        snap();
        do_req(2'd3, 8'hFF, 16'd0, 1'b0);
        check("t4_ready_after", 32'(req_ready), 32'd1);
        bad = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (!req_ready || busy) bad++;
        end
        check("t4_stay_idle", 32'(bad), 32'd0);
        check("t4_err_count", 32'(err_cnt - b_err), 32'd1);
        check("t4_no_sck", 32'(sck_rises - b_rise), 32'd0);
        check("t4_no_sel", 32'((lo_ss2 - b_ss2) + (lo_ss3 - b_ss3) + (lo_conf - b_conf)), 32'd0);
        check("t4_no_done", 32'(done_cnt - b_done), 32'd0);

        // 5: reset in the middle of a payload byte
        snap();
        push_tx(8'hA5);
        push_tx(8'h3C);
        slv_vec = {8'h00, 8'h81, 8'h7E, 40'h0};
        do_req(2'd1, 8'h55, 16'd2, 1'b0);
        cycles(85);
        reset_n = 1'b0;
        @(negedge clk_sys);
        check("t5_rst_selects", 32'({spi_ss2_n, spi_ss3_n, conf_data0_n}), 32'h7);
        check("t5_rst_sck_busy", 32'({spi_sck, busy}), 32'h0);
        check("t5_rst_rx_data", 32'(rx_data), 32'h0);
        check("t5_no_rx_no_done", 32'((rx_cnt - b_rx) + (done_cnt - b_done)), 32'd0);
        reset_n = 1'b1;
        cycles(2);
        tx_tail = tx_head;
        snap();
        push_tx(8'h5A);
        slv_vec = {8'h00, 8'h99, 48'h0};
        do_req(2'd1, 8'h3A, 16'd1, 1'b0);
        wait_done(b_done + 1);
        cycles(4);
        check("t5_rx_count", 32'(rx_cnt - b_rx), 32'd1);
        check("t5_rx0", 32'(rx_mem[b_rx % 16]), 32'h99);
        check("t5_mosi", mosi_sh[15:0], 32'h3A5A);

        // 6: back-to-back with req_valid held
        snap();
        do_req(2'd2, 8'hA0, 16'd0, 1'b1);
        do_req(2'd0, 8'h0F, 16'd0, 1'b0);
        wait_done(b_done + 2);
        cycles(4);
        check("t6_done_count", 32'(done_cnt - b_done), 32'd2);
        check("t6_gap_ge_setup", 32'(last_gap >= 2), 32'd1);
        check("t6_sck_rises", 32'(sck_rises - b_rise), 32'd16);
        check("t6_mosi", mosi_sh[15:0], 32'hA00F);
        check("t6_ss3_low_cycles", 32'(lo_ss3 - b_ss3), 32'd68);
        check("t6_conf_low_cycles", 32'(lo_conf - b_conf), 32'd68);

        check("one_select_only", 32'(multi_sel), 32'd0);
        check("select_stable_sck_high", 32'(sel_sck_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
